// File: rtl/fifo_sync_ex_pkg.sv
// fifo_sync_ex_pkg: read-mode names and configuration check shared by the FIFO and its users
package fifo_sync_ex_pkg;
  localparam string MODE_NORMAL = "NORMAL";
  localparam string MODE_FWFT = "FWFT";
  function automatic bit cfg_ok(string mode, int depth, int afull, int aempty);
    return (mode == MODE_NORMAL || mode == MODE_FWFT) &&
           afull >= 1 && afull <= depth && aempty >= 0 && aempty < depth;
  endfunction
endpackage

// File: rtl/fifo_sync_ram.sv
// fifo_sync_ram: simple dual-port RAM, synchronous write and enabled synchronous read, no reset
module fifo_sync_ram #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] q
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) q <= mem[raddr];
  end
endmodule

// File: rtl/fifo_sync_ex.sv
// fifo_sync_ex: single-clock FIFO with NORMAL/FWFT read modes, programmable thresholds and flush
module fifo_sync_ex
  import fifo_sync_ex_pkg::*;
#(
  parameter int    DSIZE         = 8,
  parameter int    ASIZE         = 4,
  parameter string MODE          = MODE_NORMAL,
  parameter int    AFULL_THRESH  = (1 << ASIZE) - 2,
  parameter int    AEMPTY_THRESH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [DSIZE-1:0] din,
  input  logic             wr_en,
  output logic             full,
  output logic             almost_full,
  output logic             overflow,
  output logic [DSIZE-1:0] dout,
  input  logic             rd_en,
  output logic             empty,
  output logic             almost_empty,
  output logic             underflow,
  output logic [ASIZE:0]   data_count
);
  localparam int DEPTH = 1 << ASIZE;
  localparam bit FWFT = MODE == MODE_FWFT;
  localparam logic [ASIZE:0] DEPTH_C = (ASIZE + 1)'(DEPTH);
  localparam logic [ASIZE:0] AF_C = (ASIZE + 1)'(AFULL_THRESH);
  localparam logic [ASIZE:0] AE_C = (ASIZE + 1)'(AEMPTY_THRESH);

  if (!cfg_ok(MODE, DEPTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_cfg
    $error("fifo_sync_ex: MODE or threshold out of range");
  end

  logic [ASIZE:0] wr_ptr, rd_ptr, cnt_nx;
  logic [DSIZE-1:0] q;
  logic wr_ok, rd_ok, ren, valid, valid_nx, hold_zero;

  // In FWFT the RAM refills the output stage whenever it is empty or being popped
  always_comb begin
    wr_ok = wr_en && !full && !flush;
    rd_ok = rd_en && !empty && !flush;
    ren = FWFT ? (wr_ptr != rd_ptr) && (!valid || rd_ok) && !flush : rd_ok;
    valid_nx = flush ? 1'b0 : ren ? 1'b1 : rd_ok ? 1'b0 : valid;
    cnt_nx = flush ? '0 : data_count + (ASIZE + 1)'(wr_ok) - (ASIZE + 1)'(rd_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      data_count <= '0;
      valid <= 1'b0;
      hold_zero <= 1'b1;
      full <= 1'b0;
      almost_full <= 1'b0;
      empty <= 1'b1;
      almost_empty <= 1'b1;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr <= flush ? '0 : wr_ptr + (ASIZE + 1)'(wr_ok);
      rd_ptr <= flush ? '0 : rd_ptr + (ASIZE + 1)'(ren);
      data_count <= cnt_nx;
      valid <= valid_nx;
      hold_zero <= flush || (hold_zero && !ren);
      full <= cnt_nx == DEPTH_C;
      almost_full <= cnt_nx >= AF_C;
      empty <= FWFT ? !valid_nx : cnt_nx == '0;
      almost_empty <= cnt_nx <= AE_C;
      overflow <= wr_en && full && !flush;
      underflow <= rd_en && empty && !flush;
    end
  end

  // The RAM output is unreset, so dout is forced to zero until the first read after reset/flush
  assign dout = hold_zero ? '0 : q;

  fifo_sync_ram #(.DW(DSIZE), .AW(ASIZE)) u_ram (
    .clk  (clk),
    .we   (wr_ok),
    .waddr(wr_ptr[ASIZE-1:0]),
    .wdata(din),
    .re   (ren),
    .raddr(rd_ptr[ASIZE-1:0]),
    .q    (q)
  );
endmodule

// File: tb/tb_fifo_sync_ex.sv
// tb_fifo_sync_ex: drives a NORMAL and a FWFT instance side by side against a queue scoreboard
module tb_fifo_sync_ex;
  typedef struct {
    logic [7:0] d;
    int         w;
  } ent_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] flush, wr_en, rd_en, full, almost_full, overflow, empty, almost_empty, underflow;
  logic [1:0][7:0] din, dout;
  logic [1:0][4:0] data_count;
  ent_t sb[2][$];
  logic [7:0] mdout[2];
  int n = 0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    fifo_sync_ex #(.MODE(g ? "FWFT" : "NORMAL")) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush[g]),
      .din         (din[g]),
      .wr_en       (wr_en[g]),
      .full        (full[g]),
      .almost_full (almost_full[g]),
      .overflow    (overflow[g]),
      .dout        (dout[g]),
      .rd_en       (rd_en[g]),
      .empty       (empty[g]),
      .almost_empty(almost_empty[g]),
      .underflow   (underflow[g]),
      .data_count  (data_count[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic string tg(string s, int m);
    return $sformatf("%s[%s]", s, m ? "fwft" : "normal");
  endfunction

  // FWFT head is visible only once it was written at least one edge before the latest edge
  function automatic bit is_empty(int m);
    return m ? !(sb[m].size() > 0 && sb[m][0].w < n) : sb[m].size() == 0;
  endfunction

  task automatic chk_reset(int m);
    chk(tg("rst_count", m), data_count[m], 0);
    chk(tg("rst_empty", m), empty[m], 1);
    chk(tg("rst_aempty", m), almost_empty[m], 1);
    chk(tg("rst_full", m), full[m], 0);
    chk(tg("rst_afull", m), almost_full[m], 0);
    chk(tg("rst_dout", m), dout[m], 0);
    chk(tg("rst_ovf", m), overflow[m], 0);
    chk(tg("rst_unf", m), underflow[m], 0);
  endtask

  task automatic step();
    logic [1:0] racc, wacc, eo, eu, fl;
    ent_t e;
    for (int m = 0; m < 2; m++) begin
      fl[m] = flush[m];
      wacc[m] = wr_en[m] && sb[m].size() < 16 && !flush[m];
      racc[m] = rd_en[m] && !is_empty(m) && !flush[m];
      eo[m] = wr_en[m] && sb[m].size() == 16 && !flush[m];
      eu[m] = rd_en[m] && is_empty(m) && !flush[m];
      if (racc[m]) begin
        e = sb[m].pop_front();
        if (m == 1) chk(tg("pop_data", m), dout[1], e.d);
        else mdout[0] = e.d;
      end
      if (wacc[m]) begin
        e.d = din[m];
        e.w = n + 1;
        sb[m].push_back(e);
      end
      if (flush[m]) begin
        sb[m].delete();
        mdout[m] = '0;
      end
    end
    @(posedge clk);
    n++;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk(tg("count", m), data_count[m], sb[m].size());
      chk(tg("empty", m), empty[m], is_empty(m));
      chk(tg("full", m), full[m], sb[m].size() == 16);
      chk(tg("afull", m), almost_full[m], sb[m].size() >= 14);
      chk(tg("aempty", m), almost_empty[m], sb[m].size() <= 2);
      chk(tg("ovf", m), overflow[m], eo[m]);
      chk(tg("unf", m), underflow[m], eu[m]);
      if (m == 0) chk(tg("dout", m), dout[0], mdout[0]);
      else if (!is_empty(1)) chk(tg("head", m), dout[1], sb[1][0].d);
      else if (fl[1]) chk(tg("flush_dout", m), dout[1], 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    flush = '0;
    wr_en = '0;
    rd_en = '0;
    din = '0;
    mdout[0] = '0;
    mdout[1] = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) chk_reset(m);
    rst_n = 1'b1;
    step();
    // NORMAL fill to full, one rejected write, drain plus one underflowing read
    wr_en[0] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      din[0] = 8'(i);
      step();
    end
    din[0] = 8'hEE;
    step();
    wr_en[0] = 1'b0;
    step();
    rd_en[0] = 1'b1;
    repeat (17) step();
    rd_en[0] = 1'b0;
    // FWFT single word, then a 40-word stream with continuous pop across pointer wrap
    din[1] = 8'hA5;
    wr_en[1] = 1'b1;
    step();
    wr_en[1] = 1'b0;
    step();
    rd_en[1] = 1'b1;
    step();
    rd_en[1] = 1'b0;
    step();
    wr_en[1] = 1'b1;
    rd_en[1] = 1'b1;
    for (int i = 0; i < 40; i++) begin
      din[1] = 8'(8'h40 + i);
      step();
    end
    wr_en[1] = 1'b0;
    repeat (3) step();
    rd_en[1] = 1'b0;
    // simultaneous read+write when full and when empty, both modes
    wr_en = 2'b11;
    for (int i = 0; i < 16; i++) begin
      din[0] = 8'(i + 8'h80);
      din[1] = 8'(~i);
      step();
    end
    rd_en = 2'b11;
    step();
    wr_en = 2'b00;
    repeat (17) step();
    wr_en = 2'b11;
    din[0] = 8'h5A;
    din[1] = 8'h3C;
    step();
    wr_en = 2'b00;
    rd_en = 2'b00;
    step();
    rd_en = 2'b11;
    repeat (3) step();
    rd_en = 2'b00;
    // flush at count 9 with both requests high
    wr_en = 2'b11;
    for (int i = 0; i < 9; i++) begin
      din[0] = 8'(i + 8'h20);
      din[1] = 8'(i + 8'h30);
      step();
    end
    flush = 2'b11;
    rd_en = 2'b11;
    step();
    flush = 2'b00;
    rd_en = 2'b00;
    din[0] = 8'hC3;
    din[1] = 8'hD4;
    step();
    wr_en = 2'b00;
    repeat (2) step();
    rd_en = 2'b11;
    repeat (2) step();
    rd_en = 2'b00;
    // asynchronous reset in the middle of a write burst
    wr_en = 2'b11;
    repeat (5) step();
    #2 rst_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk_reset(m);
      sb[m].delete();
      mdout[m] = '0;
    end
    wr_en = 2'b00;
    @(posedge clk);
    n++;
    #1;
    for (int m = 0; m < 2; m++) chk_reset(m);
    rst_n = 1'b1;
    step();
    // random traffic: write-heavy then read-heavy, rare flushes
    for (int k = 0; k < 400; k++) begin
      for (int m = 0; m < 2; m++) begin
        wr_en[m] = $urandom_range(0, 99) < (k < 200 ? 70 : 35);
        rd_en[m] = $urandom_range(0, 99) < (k < 200 ? 40 : 75);
        flush[m] = $urandom_range(0, 99) == 0;
        din[m] = 8'($urandom);
      end
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
